// File: rtl/mem_pkg.sv
// Shared decode constants and state type for the RV32I Memory stage.
package mem_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // ADDI x0,x0,0 used as the Writeback bubble
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_load_format.sv
// Extracts the addressed byte/half/word from a read word and sign/zero extends it.
module mem_load_format
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        result = '0;
        case (funct3)
            F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   result = rdata;
            F3_LBU:  result = {24'h0, shifted[7:0]};
            F3_LHU:  result = {16'h0, shifted[15:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: issues loads/stores over a req/ready handshake, formats load data,
// and stalls upstream while an access is outstanding.
module mem_access #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] NOP_INST = mem_pkg::NOP_INST
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         mem_inst,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         exe_result,
    output logic                mem_stall,
    output logic [31:0]         mem_result,
    output logic [31:0]         wb_inst,
    output logic                mem_fault,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [31:0]         dmem_addr,
    output logic [31:0]         dmem_wdata,
    output logic [3:0]          dmem_wstrb,
    input  logic                dmem_ready,
    input  logic [31:0]         dmem_rdata,
    output mem_pkg::mem_state_t dbg_state
);
    import mem_pkg::*;

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // dmem handshake: dmem_req is registered and, once raised, it and every dmem_*
    // field stay stable until a cycle with dmem_ready=1 (transfer) or the timeout.
    mem_state_t state, state_next;
    logic [CNT_W-1:0] counter;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [1:0] offset;
    logic       is_load, is_store, is_mem;
    logic       legal_f3, misaligned;
    logic       access_ok, access_bad;

    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;

    logic        timeout_hit;
    logic        issue, complete, abort, fault_set;

    logic [2:0]  acc_funct3;
    logic [1:0]  acc_offset;
    logic        acc_load;
    logic [31:0] load_data;

    assign opcode   = mem_inst[6:0];
    assign funct3   = mem_inst[14:12];
    assign offset   = mem_addr[1:0];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_mem   = is_load || is_store;

    always_comb begin
        legal_f3   = 1'b0;
        misaligned = 1'b0;
        if (is_load) begin
            case (funct3)
                F3_LB, F3_LBU: legal_f3 = 1'b1;
                F3_LH, F3_LHU: begin
                    legal_f3   = 1'b1;
                    misaligned = offset[0];
                end
                F3_LW: begin
                    legal_f3   = 1'b1;
                    misaligned = |offset;
                end
                default: legal_f3 = 1'b0;
            endcase
        end else if (is_store) begin
            case (funct3)
                F3_SB: legal_f3 = 1'b1;
                F3_SH: begin
                    legal_f3   = 1'b1;
                    misaligned = offset[0];
                end
                F3_SW: begin
                    legal_f3   = 1'b1;
                    misaligned = |offset;
                end
                default: legal_f3 = 1'b0;
            endcase
        end
    end

    assign access_ok  = is_mem && legal_f3 && !misaligned;
    assign access_bad = is_mem && !access_ok;

    // Narrow stores replicate the data across lanes; the strobes pick the live ones.
    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = exe_result;
        case (funct3)
            F3_SB: begin
                st_wstrb = 4'b0001 << offset;
                st_wdata = {4{exe_result[7:0]}};
            end
            F3_SH: begin
                st_wstrb = 4'b0011 << offset;
                st_wdata = {2{exe_result[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = exe_result;
            end
        endcase
    end

    assign timeout_hit = (counter == CNT_W'(TIMEOUT - 1)) && !dmem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (access_ok) state_next = BUSY;
            BUSY:    if (dmem_ready || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_stall = 1'b0;
        issue     = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        fault_set = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = access_ok;
                issue     = access_ok;
                fault_set = access_bad;
            end
            BUSY: begin
                // ready releases upstream in the same cycle so the next instruction lands at this edge
                mem_stall = !dmem_ready;
                complete  = dmem_ready;
                abort     = timeout_hit;
                fault_set = timeout_hit;
            end
            default: mem_stall = 1'b0;
        endcase
    end

    assign dbg_state = state;

    mem_load_format u_load_format (
        .rdata  (dmem_rdata),
        .funct3 (acc_funct3),
        .offset (acc_offset),
        .result (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter    <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= '0;
            mem_result <= '0;
            wb_inst    <= NOP_INST;
            mem_fault  <= 1'b0;
            acc_funct3 <= '0;
            acc_offset <= '0;
            acc_load   <= 1'b0;
        end else begin
            mem_fault <= fault_set;
            if (issue) begin
                dmem_req   <= 1'b1;
                dmem_we    <= is_store;
                dmem_addr  <= {mem_addr[31:2], 2'b00};
                dmem_wdata <= is_store ? st_wdata : '0;
                dmem_wstrb <= is_store ? st_wstrb : 4'b0000;
                acc_funct3 <= funct3;
                acc_offset <= offset;
                acc_load   <= is_load;
                counter    <= '0;
                wb_inst    <= NOP_INST;
            end else if (state == IDLE) begin
                if (access_bad) begin
                    wb_inst    <= NOP_INST;
                    mem_result <= '0;
                end else begin
                    wb_inst    <= mem_inst;
                    mem_result <= exe_result;
                end
            end else if (complete) begin
                dmem_req   <= 1'b0;
                dmem_we    <= 1'b0;
                dmem_wstrb <= 4'b0000;
                wb_inst    <= mem_inst;
                mem_result <= acc_load ? load_data : '0;
            end else if (abort) begin
                dmem_req   <= 1'b0;
                dmem_we    <= 1'b0;
                dmem_wstrb <= 4'b0000;
                wb_inst    <= NOP_INST;
                mem_result <= '0;
            end else begin
                counter <= counter + 1'b1;
                wb_inst <= NOP_INST;
            end
        end
    end

endmodule
